// File: rtl/cache_traffic_gen.sv
// Cache traffic generator: walks sequential, LFSR-random or strided addresses and reports counts/latency.
// Optional TGEN_CHECK_EN: write-then-read per address with read-back data checking.
module cache_traffic_gen #(
  parameter int                    ADDR_WIDTH = 11,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    CNT_WIDTH  = 16,
  parameter int                    LAT_WIDTH  = 8,
  parameter int                    TIMEOUT    = 200,
  parameter logic [15:0]           SEED       = 16'hACE1,
  parameter logic [DATA_WIDTH-1:0] PATTERN    = 'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic                  rw_mode,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] stride,
  input  logic [CNT_WIDTH-1:0]  num_req,
  output logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic [DATA_WIDTH-1:0] cpu_data_in,
  output logic                  cpu_read,
  output logic                  cpu_write,
  input  logic [DATA_WIDTH-1:0] cpu_data_out,
  input  logic                  cpu_ready,
  input  logic                  cpu_hit,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic [CNT_WIDTH-1:0]  req_count,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [LAT_WIDTH-1:0]  max_latency
);
  localparam logic [2:0] S_IDLE  = 3'd0, S_ISSUE = 3'd1, S_GUARD = 3'd2,
                         S_WAIT  = 3'd3, S_CHECK = 3'd4, S_DONE  = 3'd5;
  localparam logic [31:0] TO_LIM = 32'(TIMEOUT);

  logic [2:0]            state_q, state_d;
  logic [15:0]           lfsr_q, lfsr_d, lfsr_nxt;
  logic [1:0]            mode_q, mode_d;
  logic                  rw_q, rw_d, wph_q, wph_d;
  logic [ADDR_WIDTH-1:0] acc_q, acc_d, stride_q, stride_d, step;
  logic [CNT_WIDTH-1:0]  num_q, num_d, idx_q, idx_d;
  logic [CNT_WIDTH-1:0]  req_q, req_d, hit_q, hit_d, err_q, err_d;
  logic [LAT_WIDTH-1:0]  lat_q, lat_d, maxl_q, maxl_d, lat_now;
  logic                  to_q, to_d, issue, data_bad;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign lfsr_nxt = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign step     = (mode_q == 2'd2) ? stride_q : ADDR_WIDTH'(1);
  // latency including the current cycle, counted from ISSUE
  assign lat_now  = (&lat_q) ? lat_q : lat_q + 1'b1;
  assign issue    = (state_q == S_ISSUE);

  assign cpu_addr    = (mode_q == 2'd1) ? lfsr_q[ADDR_WIDTH-1:0] : acc_q;
  assign cpu_read    = issue && !wph_q;
  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done        = (state_q == S_DONE);
  assign timeout     = to_q;
  assign req_count   = req_q;
  assign hit_count   = hit_q;
  assign max_latency = maxl_q;

`ifdef TGEN_CHECK_EN
  localparam bit CHK_EN = 1'b1;
  logic [DATA_WIDTH-1:0] wdata;
  assign wdata       = DATA_WIDTH'(cpu_addr) ^ PATTERN;
  assign data_bad    = rw_q && (cpu_data_out != wdata);
  assign cpu_write   = issue && wph_q;
  assign cpu_data_in = (wph_q && busy) ? wdata : '0;
  assign err_count   = err_q;
`else
  localparam bit CHK_EN = 1'b0;
  logic unused_nc;
  assign unused_nc   = ^{cpu_data_out, err_q};
  assign data_bad    = 1'b0;
  assign cpu_write   = 1'b0;
  assign cpu_data_in = '0;
  assign err_count   = '0;
`endif

  always_comb begin
    state_d = state_q; lfsr_d = lfsr_q; mode_d = mode_q; rw_d = rw_q; wph_d = wph_q;
    acc_d = acc_q; stride_d = stride_q; num_d = num_q; idx_d = idx_q;
    req_d = req_q; hit_d = hit_q; err_d = err_q; lat_d = lat_q; maxl_d = maxl_q; to_d = to_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) begin
        mode_d = mode; rw_d = CHK_EN && rw_mode; wph_d = CHK_EN && rw_mode;
        acc_d = base_addr; stride_d = stride; num_d = num_req; idx_d = '0;
        req_d = '0; hit_d = '0; err_d = '0; maxl_d = '0; to_d = 1'b0; lfsr_d = SEED;
        state_d = (num_req == '0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin lat_d = LAT_WIDTH'(1); state_d = S_GUARD; end
      S_GUARD: begin lat_d = lat_now; state_d = S_WAIT; end
      S_WAIT: begin
        if (cpu_ready) begin
          req_d = sat_inc(req_q);
          if (cpu_hit) hit_d = sat_inc(hit_q);
          if (lat_now > maxl_q) maxl_d = lat_now;
          state_d = S_CHECK;
        end else if (32'(lat_now) >= TO_LIM) begin
          to_d = 1'b1; state_d = S_DONE;
        end else begin
          lat_d = lat_now;
        end
      end
      S_CHECK: begin
        if (wph_q) begin
          wph_d = 1'b0; state_d = S_ISSUE;
        end else begin
          if (data_bad) err_d = sat_inc(err_q);
          lfsr_d = lfsr_nxt; acc_d = acc_q + step; idx_d = idx_q + 1'b1;
          if (idx_q + 1'b1 == num_q) state_d = S_DONE;
          else begin wph_d = rw_q; state_d = S_ISSUE; end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE; lfsr_q <= SEED; mode_q <= '0; rw_q <= 1'b0; wph_q <= 1'b0;
      acc_q <= '0; stride_q <= '0; num_q <= '0; idx_q <= '0;
      req_q <= '0; hit_q <= '0; err_q <= '0; lat_q <= '0; maxl_q <= '0; to_q <= 1'b0;
    end else begin
      state_q <= state_d; lfsr_q <= lfsr_d; mode_q <= mode_d; rw_q <= rw_d; wph_q <= wph_d;
      acc_q <= acc_d; stride_q <= stride_d; num_q <= num_d; idx_q <= idx_d;
      req_q <= req_d; hit_q <= hit_d; err_q <= err_d; lat_q <= lat_d; maxl_q <= maxl_d; to_q <= to_d;
    end
  end
endmodule

// File: tb/tb_cache_traffic_gen.sv
// Randomized bench for cache_traffic_gen: scoreboard of expected accesses plus a responding cache model.
module tb_cache_traffic_gen;
  localparam int AW = 11, DW = 8, CW = 16, LW = 8;
`ifdef TGEN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0, rst, start, rw_mode;
  logic [1:0] mode;
  logic [AW-1:0] base_addr, stride, cpu_addr;
  logic [CW-1:0] num_req, req_count, hit_count, err_count;
  logic [DW-1:0] cpu_data_in, cpu_data_out;
  logic cpu_read, cpu_write, cpu_ready, cpu_hit, busy, done, timeout;
  logic [LW-1:0] max_latency;

  cache_traffic_gen dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .rw_mode(rw_mode),
    .base_addr(base_addr), .stride(stride), .num_req(num_req),
    .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_data_out(cpu_data_out), .cpu_ready(cpu_ready), .cpu_hit(cpu_hit),
    .busy(busy), .done(done), .timeout(timeout), .req_count(req_count),
    .hit_count(hit_count), .err_count(err_count), .max_latency(max_latency));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  typedef struct { bit wr; logic [AW-1:0] a; logic [DW-1:0] d; } op_t;
  op_t exp_q[$];
  logic [AW-1:0] seen_q[$];

  // cache model state
  logic [DW-1:0] mem [0:(1<<AW)-1];
  int pend = 0, cnt = 0, stale = 0, lat_c = 0, maxlat_m = 0, hits_m = 0, dfix = 0, dmax = 8;
  bit never = 0, corrupt = 0, fire, cur_w;
  logic [AW-1:0] cur_a;
  time t_strobe;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Expected access list for a run, straight from the address rules.
  task automatic build(input logic [1:0] m, input bit rw, input logic [AW-1:0] b,
                       input logic [AW-1:0] s, input int n);
    logic [15:0] l;
    logic [AW-1:0] a;
    l = 16'hACE1;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      case (m)
        2'd1:    a = l[AW-1:0];
        2'd2:    a = b + AW'(i) * s;
        default: a = b + AW'(i);
      endcase
      if (CHK && rw) exp_q.push_back('{1'b1, a, DW'(a) ^ 8'hA5});
      exp_q.push_back('{1'b0, a, '0});
      l = lfsr_step(l);
    end
  endtask

  // Cache responder: ready d cycles after the strobe (d>=2), then optionally lingering up to 3 cycles.
  initial begin
    cpu_ready = 0; cpu_hit = 0; cpu_data_out = '0;
    forever begin
      @(negedge clk);
      if (rst) begin pend = 0; stale = 0; cpu_ready = 0; continue; end
      fire = 0;
      if (cpu_read || cpu_write) begin
        cur_a = cpu_addr; cur_w = cpu_write; t_strobe = $time;
        if (cpu_write) mem[cpu_addr] = cpu_data_in;
        cnt = (dfix > 0) ? dfix : $urandom_range(dmax, 2);
        lat_c = cnt + 1;
        pend = never ? 0 : 1;
      end else if (pend != 0) begin
        cnt--;
        if (cnt == 0) begin fire = 1; pend = 0; end
      end
      cpu_hit = 1'($urandom_range(1, 0));
      if (fire) begin
        cpu_ready = 1;
        if (cpu_hit) hits_m++;
        if (lat_c > maxlat_m) maxlat_m = lat_c;
        cpu_data_out = mem[cur_a] ^ DW'((corrupt && !cur_w && cur_a == AW'(5)) ? 1 : 0);
        stale = $urandom_range(3, 0);
      end else if (stale > 0) begin
        cpu_ready = 1; stale--;
      end else cpu_ready = 0;
    end
  end

  // Compare process: every strobe must match the head of the expected list.
  initial begin
    op_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("busy_and_done", 32'(busy & done), 0);
        if (cpu_read || cpu_write) begin
          seen_q.push_back(cpu_addr);
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_strobe addr=%0h rd=%0b wr=%0b", cpu_addr, cpu_read, cpu_write);
          end else begin
            e = exp_q.pop_front();
            chk("addr", 32'(cpu_addr), 32'(e.a));
            chk("op", {30'd0, cpu_read, cpu_write}, e.wr ? 32'd1 : 32'd2);
            if (e.wr) chk("wdata", 32'(cpu_data_in), 32'(e.d));
            chk("busy_issue", 32'(busy), 1);
          end
        end
      end
    end
  end

  task automatic chk_zero(input string p);
    chk({p, "_rd"}, 32'(cpu_read), 0);       chk({p, "_wr"}, 32'(cpu_write), 0);
    chk({p, "_addr"}, 32'(cpu_addr), 0);     chk({p, "_din"}, 32'(cpu_data_in), 0);
    chk({p, "_busy"}, 32'(busy), 0);         chk({p, "_done"}, 32'(done), 0);
    chk({p, "_to"}, 32'(timeout), 0);        chk({p, "_req"}, 32'(req_count), 0);
    chk({p, "_hit"}, 32'(hit_count), 0);     chk({p, "_err"}, 32'(err_count), 0);
    chk({p, "_maxl"}, 32'(max_latency), 0);
  endtask

  task automatic run(input string nm, input logic [1:0] m, input bit rw, input logic [AW-1:0] b,
                     input logic [AW-1:0] s, input int n, input int dfx, input bit nev,
                     input bit poke, input bit corr);
    int cyc, nreq, nerr;
    bit poked;
    time t_done;
    build(m, rw, b, s, n);
    nerr = 0;
    if (CHK && rw && corr) foreach (exp_q[i]) if (!exp_q[i].wr && exp_q[i].a == AW'(5)) nerr++;
    nreq = nev ? 0 : n * ((CHK && rw) ? 2 : 1);
    seen_q.delete(); maxlat_m = 0; hits_m = 0; dfix = dfx; never = nev; corrupt = corr;
    mode = m; rw_mode = rw; base_addr = b; stride = s; num_req = CW'(n);
    start = 1; @(negedge clk); start = 0;
    cyc = 0; poked = 0;
    while (!done && cyc < 5000) begin
      if (poke && !poked && seen_q.size() >= 5) begin
        start = 1; base_addr = ~b; mode = m + 2'd1; num_req = CW'(n + 3); poked = 1;
      end else start = 0;
      @(negedge clk); cyc++;
    end
    start = 0; t_done = $time;
    chk({nm, "_done"}, 32'(done), 1);
    chk({nm, "_busy"}, 32'(busy), 0);
    if (!nev) chk({nm, "_left"}, 32'(exp_q.size()), 0);
    chk({nm, "_req"}, 32'(req_count), 32'(nreq));
    chk({nm, "_hit"}, 32'(hit_count), 32'(hits_m));
    chk({nm, "_maxl"}, 32'(max_latency), 32'(maxlat_m));
    chk({nm, "_err"}, 32'(err_count), 32'(nerr));
    chk({nm, "_to"}, 32'(timeout), 32'(nev));
    if (nev) chk({nm, "_to_cycles"}, 32'((t_done - t_strobe) / 10), 200);
    repeat (3) @(negedge clk);
    chk({nm, "_hold_done"}, 32'(done), 1);
    chk({nm, "_hold_req"}, 32'(req_count), 32'(nreq));
    exp_q.delete(); never = 0; corrupt = 0; dfix = 0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst = 1; start = 0; mode = 0; rw_mode = 0; base_addr = 0; stride = 0; num_req = 0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    repeat (2) @(negedge clk);
    chk_zero("rst");
    rst = 0; @(negedge clk);

    // Pin the model against hand-computed values.
    chk("lfsr_step_ace1", 32'(lfsr_step(16'hACE1)), 32'hE270);
    build(2'd1, 1'b0, '0, '0, 2);
    chk("model_rnd_a0", 32'(exp_q[0].a), 32'h4E1);
    chk("model_rnd_a1", 32'(exp_q[CHK ? 0 : 1].a), CHK ? 32'h4E1 : 32'h270);
    exp_q.delete();

    // Sequential wrap-around
    run("seq", 2'd0, 1'b0, 11'h7F0, '0, 32, 0, 0, 0, 0);
    chk("seq_a0", 32'(seen_q[0]), 32'h7F0);
    chk("seq_a15", 32'(seen_q[15]), 32'h7FF);
    chk("seq_a16", 32'(seen_q[16]), 32'h000);
    chk("seq_a31", 32'(seen_q[31]), 32'h00F);
    chk("seq_req32", 32'(req_count), 32);

    // Stride, ready 3 cycles after strobe
    run("stride", 2'd2, 1'b0, '0, 11'd16, 4, 3, 0, 0, 0);
    chk("stride_a3", 32'(seen_q[3]), 32'h030);
    chk("stride_maxl4", 32'(max_latency), 4);

    // num_req = 0
    mode = 0; num_req = 0; exp_q.delete();
    start = 1; @(negedge clk); start = 0;
    chk("zero_done", 32'(done), 1);
    chk("zero_req", 32'(req_count), 0);
    repeat (4) @(negedge clk);
    chk("zero_done_hold", 32'(done), 1);

    // Timeout with ready never returned
    run("tmo", 2'd0, 1'b0, 11'h100, '0, 2, 0, 1, 0, 0);

    // Randomized runs, some with a start pulse while busy
    for (int k = 0; k < 8; k++) begin
      dmax = $urandom_range(8, 2);
      run($sformatf("rnd%0d", k), 2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
          AW'($urandom), AW'($urandom), $urandom_range(40, 1), 0, 0, k[0], 0);
    end
    dmax = 8;

    // Write-then-read with data checking
    run("wr_ok", 2'd0, 1'b1, '0, '0, 8, 0, 0, 1, 0);
    run("wr_bad", 2'd0, 1'b1, '0, '0, 8, 0, 0, 0, 1);
    if (CHK) chk("wr_bad_err1", 32'(err_count), 1);

    // Reset during WAIT of the third random request, then replay
    build(2'd1, 1'b0, '0, '0, 10);
    seen_q.delete(); dfix = 6;
    mode = 2'd1; rw_mode = 0; num_req = 10;
    start = 1; @(negedge clk); start = 0;
    cyc = 0;
    while (seen_q.size() < 3 && cyc < 500) begin @(negedge clk); cyc++; end
    chk("rst_reach_3rd", 32'(seen_q.size()), 3);
    repeat (2) @(negedge clk);
    chk("rst_in_wait_busy", 32'(busy), 1);
    #2 rst = 1;
    #1 chk_zero("midrst");
    @(negedge clk); @(negedge clk);
    rst = 0; exp_q.delete(); dfix = 0;
    @(negedge clk);
    run("replay", 2'd1, 1'b0, '0, '0, 10, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
